// File: rtl/data_sram_responder.sv
// Responder end of the core data SRAM port: word-addressed array with byte-lane writes,
// read-first 1-cycle read data, and saturating read/write access counters.
// Optional macro DATA_SRAM_BOUND_CHECK_EN: out-of-range accesses return a marker word, are
// never written, and set a sticky addr_err flag.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        cnt_clr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LANES = 4;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           offset_c;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic                  in_range_c;
  logic                  accept_c;
  logic                  rd_req_c;
  logic                  wr_req_c;
  logic                  mem_wr_c;
  logic [31:0]           rdata_nxt_c;

  // Word index relative to the base; upper bits fall away so the index wraps modulo DEPTH.
  assign offset_c = data_sram_addr - BASE_ADDR;
  assign idx_c    = ADDR_WIDTH'(offset_c >> 2);

`ifdef DATA_SRAM_BOUND_CHECK_EN
  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;
  localparam logic [32:0] RANGE_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0] RANGE_HI  = RANGE_LO + (33'(DEPTH) << 2);

  logic [32:0] addr_ext_c;

  // 33-bit compare so a window ending at the top of the address space does not overflow.
  assign addr_ext_c  = {1'b0, data_sram_addr};
  assign in_range_c  = (addr_ext_c >= RANGE_LO) && (addr_ext_c < RANGE_HI);
  assign rdata_nxt_c = in_range_c ? mem[idx_c] : OOR_RDATA;
`else
  assign in_range_c  = 1'b1;
  assign rdata_nxt_c = mem[idx_c];
`endif

  assign accept_c = resetn & data_sram_en;
  assign rd_req_c = accept_c & (data_sram_we == 4'b0000);
  assign wr_req_c = accept_c & (data_sram_we != 4'b0000);
  assign mem_wr_c = wr_req_c & in_range_c;

  // Array is deliberately left out of reset so it can hold a preloaded image.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      for (int i = 0; i < LANES; i++) begin
        if (data_sram_we[i]) begin
          mem[idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read-first: a write cycle returns the word as it was before this edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_sram_rdata <= RESET_RDATA;
    end else if (accept_c) begin
      data_sram_rdata <= rdata_nxt_c;
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else if (cnt_clr) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else begin
      if (rd_req_c && (rd_cnt != CNT_MAX)) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (wr_req_c && (wr_cnt != CNT_MAX)) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

`ifdef DATA_SRAM_BOUND_CHECK_EN
  // Sticky until reset once any accepted request misses the mapped window.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_err <= 1'b0;
    end else if (accept_c && !in_range_c) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a reference memory model predicts rdata per cycle,
// expectations are queued as stimulus is driven and popped when the DUT output settles.
module tb_data_sram_responder;

  localparam int unsigned AW      = 4;
  localparam int unsigned WORDS   = 1 << AW;
  localparam logic [31:0] RST_VAL = 32'hCAFE_0001;
  localparam logic [31:0] OOR_VAL = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] val;
    bit          known;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        cnt_clr = 1'b0;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        addr_err;

  exp_t        sb[$];
  logic [31:0] mem_m [WORDS];
  bit          kn_m  [WORDS];
  logic [31:0] last_m = RST_VAL;
  bit          last_kn = 1'b1;
  logic [31:0] rd_m = 32'h0;
  logic [31:0] wr_m = 32'h0;
  logic        err_m = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  data_sram_responder #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (32'h0000_0000),
    .RESET_RDATA(RST_VAL)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .cnt_clr        (cnt_clr),
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; the model predicts rdata after the coming edge and queues it.
  task automatic drive(input bit rst, input bit en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd, input bit clr);
    exp_t e;
    int   idx;
    bit   inr;
    @(negedge clk);
    resetn          = !rst;
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    cnt_clr         = clr;
    if (rst) begin
      rd_m = 0; wr_m = 0; err_m = 1'b0;
      last_m = RST_VAL; last_kn = 1'b1;
    end else begin
      if (en) begin
        idx = int'((addr >> 2) % WORDS);
        inr = 1'b1;
`ifdef DATA_SRAM_BOUND_CHECK_EN
        inr = (addr < 32'(WORDS * 4));
`endif
        if (inr) begin
          last_m = mem_m[idx]; last_kn = kn_m[idx];
          for (int i = 0; i < 4; i++)
            if (we[i]) mem_m[idx][8*i +: 8] = wd[8*i +: 8];
          if (we == 4'hF) kn_m[idx] = 1'b1;
        end else begin
          last_m = OOR_VAL; last_kn = 1'b1; err_m = 1'b1;
        end
      end
      if (clr) begin
        rd_m = 0; wr_m = 0;
      end else if (en) begin
        if (we == 4'h0) begin
          if (rd_m != 32'hFFFF_FFFF) rd_m = rd_m + 1;
        end else if (wr_m != 32'hFFFF_FFFF) begin
          wr_m = wr_m + 1;
        end
      end
    end
    e.val = last_m; e.known = last_kn;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1, 1, 4'hF, 32'h8, 32'h0BAD_0BAD, 0);
    void'(sb.pop_front());
    drive(1, 0, 4'h0, 32'h0, 32'h0, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL reset_rdata: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    n_chk++;
    if ({rd_cnt, wr_cnt, addr_err} !== {rd_m, wr_m, err_m})
      $display("FAIL reset_state: got rd=%h wr=%h err=%b want rd=%h wr=%h err=%b",
               rd_cnt, wr_cnt, addr_err, rd_m, wr_m, err_m);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 4'(1 + $urandom_range(0, 14)), $urandom, $urandom, 0);
      e = sb.pop_front(); n_chk++;
      if (data_sram_rdata !== e.val) $display("FAIL idle_rdata[%0d]: got %h want %h", i, data_sram_rdata, e.val);
      else n_pass++;
    end
    n_chk++;
    if ({rd_cnt, wr_cnt, addr_err} !== {rd_m, wr_m, err_m})
      $display("FAIL idle_state: got rd=%h wr=%h err=%b want rd=%h wr=%h err=%b",
               rd_cnt, wr_cnt, addr_err, rd_m, wr_m, err_m);
    else n_pass++;
  endtask

  task automatic test_full_write_read();
    exp_t e;
    drive(0, 1, 4'hF, 32'h40, 32'h1234_5678, 0);
    e = sb.pop_front();
    if (e.known) begin
      n_chk++;
      if (data_sram_rdata !== e.val) $display("FAIL full_wr_rdata: got %h want %h", data_sram_rdata, e.val);
      else n_pass++;
    end
    drive(0, 1, 4'h0, 32'h40, 32'h0, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL full_rd_rdata: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    n_chk++;
    if ({rd_cnt, wr_cnt} !== {rd_m, wr_m})
      $display("FAIL full_counts: got rd=%h wr=%h want rd=%h wr=%h", rd_cnt, wr_cnt, rd_m, wr_m);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    exp_t e;
    drive(0, 1, 4'b0101, 32'h40, 32'hAABB_CCDD, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL lane_wr_readfirst: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    drive(0, 1, 4'h0, 32'h40, 32'h0, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL lane_rd_merged: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'hF, 32'(4 * i), 32'(i + 1), 0);
      e = sb.pop_front();
      if (e.known) begin
        n_chk++;
        if (data_sram_rdata !== e.val) $display("FAIL stream_wr[%0d]: got %h want %h", i, data_sram_rdata, e.val);
        else n_pass++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'h0, 32'(4 * i), 32'h0, 0);
      e = sb.pop_front(); n_chk++;
      if (data_sram_rdata !== e.val) $display("FAIL stream_rd[%0d]: got %h want %h", i, data_sram_rdata, e.val);
      else n_pass++;
    end
    n_chk++;
    if ({rd_cnt, wr_cnt} !== {rd_m, wr_m})
      $display("FAIL stream_counts: got rd=%h wr=%h want rd=%h wr=%h", rd_cnt, wr_cnt, rd_m, wr_m);
    else n_pass++;
  endtask

  task automatic test_reset_ignore();
    exp_t e;
    drive(0, 1, 4'h0, 32'h4, 32'h0, 0);
    void'(sb.pop_front());
    drive(1, 1, 4'hF, 32'h4, 32'hBAD0_BAD0, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL rst_after_req_rdata: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    drive(0, 1, 4'h0, 32'h4, 32'h0, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL rst_write_ignored: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    n_chk++;
    if ({rd_cnt, wr_cnt, addr_err} !== {rd_m, wr_m, err_m})
      $display("FAIL rst_counts: got rd=%h wr=%h err=%b want rd=%h wr=%h err=%b",
               rd_cnt, wr_cnt, addr_err, rd_m, wr_m, err_m);
    else n_pass++;
  endtask

  task automatic test_counters();
    exp_t e;
    drive(0, 0, 4'h0, 32'h0, 32'h0, 0);
    void'(sb.pop_front());
    @(negedge clk);
    force dut.rd_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt;
    rd_m = 32'hFFFF_FFFF;
    drive(0, 1, 4'h0, 32'h8, 32'h0, 0);
    e = sb.pop_front(); n_chk++;
    if (rd_cnt !== rd_m) $display("FAIL rd_cnt_saturate: got %h want %h", rd_cnt, rd_m);
    else n_pass++;
    n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL sat_rd_rdata: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    drive(0, 1, 4'h0, 32'hC, 32'h0, 1);
    e = sb.pop_front(); n_chk++;
    if ({rd_cnt, wr_cnt} !== {rd_m, wr_m})
      $display("FAIL cnt_clr_priority: got rd=%h wr=%h want rd=%h wr=%h", rd_cnt, wr_cnt, rd_m, wr_m);
    else n_pass++;
    n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL clr_rd_rdata: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
  endtask

  task automatic test_bound();
    exp_t e;
    drive(0, 1, 4'hF, 32'h0, 32'h5555_AAAA, 0);
    void'(sb.pop_front());
    drive(0, 1, 4'hF, 32'h40, 32'h1111_1111, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL bound_wr_rdata: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    n_chk++;
    if ({wr_cnt, addr_err} !== {wr_m, err_m})
      $display("FAIL bound_wr_state: got wr=%h err=%b want wr=%h err=%b", wr_cnt, addr_err, wr_m, err_m);
    else n_pass++;
    drive(0, 1, 4'h0, 32'h0, 32'h0, 0);
    e = sb.pop_front(); n_chk++;
    if (data_sram_rdata !== e.val) $display("FAIL bound_rd_word0: got %h want %h", data_sram_rdata, e.val);
    else n_pass++;
    n_chk++;
    if (addr_err !== err_m) $display("FAIL bound_err_sticky: got %b want %b", addr_err, err_m);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem_m[i] = 32'h0;
      kn_m[i]  = 1'b0;
    end
    test_reset();
    test_full_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_reset_ignore();
    test_counters();
    test_bound();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
